// File: rtl/fp_result_serializer.sv
// Framed parallel-to-serial result transmitter: start, data, optional parity, stop.
// Define FPSER_PARITY_EN to insert an even-parity bit between data and stop.
module fp_result_serializer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  input  logic             HOLD,
  output logic             SOUT,
  output logic             SFRAME,
  output logic             SSTB,
  output logic             DONE
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef FPSER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             sframe_q, sframe_d;
  logic             sstb_q, sstb_d;
  logic             done_q, done_d;
`ifdef FPSER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [WIDTH-1:0] shifted;
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    sstb_d  = 1'b0;
`ifdef FPSER_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == IDLE) begin
      if (LOAD) begin
        shreg_d = DIN;
        state_d = START;
        div_d   = '0;
        bit_d   = '0;
`ifdef FPSER_PARITY_EN
        par_d   = ^DIN;
`endif
      end
    end else if (!HOLD) begin
      if (div_q != DIV_LAST) begin
        div_d = div_q + 1'b1;
      end else begin
        div_d = '0;
        unique case (state_q)
          START: state_d = DATA;
          DATA: begin
            shreg_d = shifted;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef FPSER_PARITY_EN
              state_d = PAR;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
`ifdef FPSER_PARITY_EN
          PAR: state_d = STOP;
`endif
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: ;
        endcase
      end
      // strobe lands in the last divider slot, only on a non-held advance
      sstb_d = (state_d == DATA) && (div_d == DIV_LAST);
    end
    ready_d  = (state_d == IDLE);
    sframe_d = (state_d != IDLE);
    sout_d   = 1'b1;
    case (state_d)
      START: sout_d = 1'b0;
      DATA:  sout_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef FPSER_PARITY_EN
      PAR:   sout_d = par_d;
`endif
      default: sout_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      ready_q  <= 1'b1;
      sout_q   <= 1'b1;
      sframe_q <= 1'b0;
      sstb_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef FPSER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      ready_q  <= ready_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      sstb_q   <= sstb_d;
      done_q   <= done_d;
`ifdef FPSER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign READY  = ready_q;
  assign SOUT   = sout_q;
  assign SFRAME = sframe_q;
  assign SSTB   = sstb_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_fp_result_serializer.sv
// Bench for fp_result_serializer: a 32-bit/DIV=4 MSB-first instance
// and an 8-bit/DIV=1 LSB-first instance against a bit-list frame model.
module tb_fp_result_serializer;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] DIN;
  logic        LOAD, HOLD;
  logic        READY, SOUT, SFRAME, SSTB, DONE;
  logic [7:0]  DIN1;
  logic        LOAD1, HOLD1;
  logic        READY1, SOUT1, SFRAME1, SSTB1, DONE1;

  int vec = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  fp_result_serializer #(.WIDTH(32), .DIV(4), .MSB_FIRST(1'b1)) u0 (
    .CLK(CLK), .CLR(CLR), .DIN(DIN), .LOAD(LOAD), .READY(READY),
    .HOLD(HOLD), .SOUT(SOUT), .SFRAME(SFRAME), .SSTB(SSTB), .DONE(DONE)
  );

  fp_result_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u1 (
    .CLK(CLK), .CLR(CLR), .DIN(DIN1), .LOAD(LOAD1), .READY(READY1),
    .HOLD(HOLD1), .SOUT(SOUT1), .SFRAME(SFRAME1), .SSTB(SSTB1), .DONE(DONE1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load0(input logic [31:0] w, input logic hl);
    chk("ready_idle0", READY, 1);
    LOAD = 1'b1; DIN = w; HOLD = hl;
    @(negedge CLK);
    LOAD = 1'b0; HOLD = 1'b0; DIN = $urandom;
  endtask

  // checks one frame on u0 starting in its first START cycle; ends in DONE cycle
  task automatic run0(input logic [31:0] w, input int hbit, input int hlen);
    bit q[$];
    int sc, len;
    bit isd, hb;
    q.push_back(1'b0);
    for (int i = 0; i < 32; i++) q.push_back(w[31-i]);
`ifdef FPSER_PARITY_EN
    q.push_back(^w);
`endif
    q.push_back(1'b1);
    sc = 0;
    for (int k = 0; k < q.size(); k++) begin
      isd = (k >= 1) && (k <= 32);
      hb  = isd && (k - 1 == hbit);
      len = 4 + (hb ? hlen : 0);
      for (int c = 0; c < len; c++) begin
        chk("sout0", SOUT, q[k]);
        chk("sframe0", SFRAME, 1);
        chk("ready_busy0", READY, 0);
        chk("done_busy0", DONE, 0);
        chk("sstb0", SSTB, isd && (c == len - 1));
        if (SSTB) sc++;
        if (hb && c == 1) HOLD = 1'b1;
        if (hb && c == 1 + hlen) HOLD = 1'b0;
        @(negedge CLK);
      end
    end
    chk("strobe_count0", sc, 32);
    chk("done_pulse0", DONE, 1);
    chk("ready_done0", READY, 1);
    chk("sout_idle0", SOUT, 1);
    chk("sframe_idle0", SFRAME, 0);
    chk("sstb_idle0", SSTB, 0);
  endtask

  task automatic load1(input logic [7:0] w);
    chk("ready_idle1", READY1, 1);
    LOAD1 = 1'b1; DIN1 = w;
    @(negedge CLK);
    LOAD1 = 1'b0; DIN1 = 8'($urandom);
  endtask

  // u1 frame; a spurious LOAD of 0xFF is raised at frame slot spur
  task automatic run1(input logic [7:0] w, input int spur);
    bit q[$];
    bit isd;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(w[i]);
`ifdef FPSER_PARITY_EN
    q.push_back(^w);
`endif
    q.push_back(1'b1);
    for (int k = 0; k < q.size(); k++) begin
      isd = (k >= 1) && (k <= 8);
      chk("sout1", SOUT1, q[k]);
      chk("sframe1", SFRAME1, 1);
      chk("ready_busy1", READY1, 0);
      chk("sstb1", SSTB1, isd);
      chk("done_busy1", DONE1, 0);
      LOAD1 = (k == spur);
      DIN1  = (k == spur) ? 8'hFF : 8'($urandom);
      @(negedge CLK);
    end
    LOAD1 = 1'b0;
    chk("done_pulse1", DONE1, 1);
    chk("ready_done1", READY1, 1);
    chk("sout_idle1", SOUT1, 1);
    chk("sframe_idle1", SFRAME1, 0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    CLR = 1'b1; LOAD = 1'b0; HOLD = 1'b0; DIN = '0;
    LOAD1 = 1'b0; HOLD1 = 1'b0; DIN1 = '0;
    #12;
    chk("rst_ready", READY, 1);
    chk("rst_sout", SOUT, 1);
    chk("rst_sframe", SFRAME, 0);
    chk("rst_sstb", SSTB, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ready1", READY1, 1);
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);

    load0(32'h3F80_0000, 1'b0);
    run0(32'h3F80_0000, -1, 0);
    load0(32'hC000_0000, 1'b0);
    run0(32'hC000_0000, -1, 0);
    @(negedge CLK);
    chk("idle_no_done", DONE, 0);
    chk("idle_sframe", SFRAME, 0);

    load0(32'h3F80_0000, 1'b0);
    run0(32'h3F80_0000, 5, 10);
    @(negedge CLK);

    load0(32'hDEAD_BEEF, 1'b0);
    repeat (13 * 4 + 1) @(negedge CLK);
    #2 CLR = 1'b1;
    #1;
    chk("clr_sout", SOUT, 1);
    chk("clr_sframe", SFRAME, 0);
    chk("clr_ready", READY, 1);
    chk("clr_done", DONE, 0);
    #1 CLR = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("post_clr_done", DONE, 0);
      chk("post_clr_sout", SOUT, 1);
    end
    load0(32'h0000_0001, 1'b0);
    run0(32'h0000_0001, -1, 0);
    @(negedge CLK);

    load1(8'hA5);
    run1(8'hA5, 4);
    repeat (3) begin
      @(negedge CLK);
      chk("no_spur_frame1", SFRAME1, 0);
      chk("no_spur_ready1", READY1, 1);
    end

    repeat (5) begin
      w = $urandom;
      load0(w, 1'($urandom_range(0, 1)));
      run0(w, $urandom_range(0, 31), $urandom_range(0, 6));
    end
    @(negedge CLK);
    repeat (8) begin
      b = 8'($urandom);
      load1(b);
      run1(b, $urandom_range(1, 8));
    end
    @(negedge CLK);
    chk("final_sframe1", SFRAME1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/fp_result_serializer.md
Name: fp_result_serializer

Overview:
- Parallel-to-serial transmitter at the FPU output boundary of the test chip.
- Captures a WIDTH-bit result word through a valid/ready handshake and shifts it out on a single pin as a framed bit stream: start bit, data bits, optional parity bit, stop bit.
- Mirrors the operand deserializer on the input side, so result words leave the pad-limited die one bit per DIV clock cycles.

Parameters:
- WIDTH, 32, result word width in bits (>=2).
- DIV, 4, clock cycles per serial bit (>=1).
- MSB_FIRST, 1, 1 = data sent bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- DIN  input  WIDTH  result word to transmit.
- LOAD  input  1  DIN valid; accepted only when READY=1.
- READY  output  1  serializer idle and able to accept a word.
- HOLD  input  1  receiver backpressure; freezes an in-progress frame.
- SOUT  output  1  serial data line; idle level 1.
- SFRAME  output  1  high from first start-bit cycle through last stop-bit cycle.
- SSTB  output  1  one-cycle pulse in the final cycle of each data bit period.
- DONE  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (CLR=1, async): state IDLE, shift register 0, counters 0. READY=1, SOUT=1, SFRAME=0, SSTB=0, DONE=0. Takes effect immediately, including mid-frame. Any partial frame is abandoned, with no DONE.
- All outputs are registered.
- States: IDLE, START, DATA, PAR (only with feature), STOP.
- Each state other than IDLE lasts DIV non-held cycles, counted by a divider count 0..DIV-1.
- IDLE:
  - READY=1, SOUT=1, SFRAME=0.
  - LOAD=1 at a clock edge captures DIN into the shift register, then enters START with READY=0.
  - LOAD while READY=0 is ignored, and DIN is not sampled.
- START: SOUT=0, SFRAME=1.
- DATA:
  - WIDTH bits, each held on SOUT for DIV cycles, in MSB_FIRST order.
  - Bit counter runs 0..WIDTH-1.
  - SSTB=1 in divider count DIV-1 of each bit when HOLD=0. Exactly WIDTH pulses per frame.
- STOP: SOUT=1, SFRAME=1.
- End of frame: after the last STOP cycle, return to IDLE. DONE=1 and READY=1 in that first IDLE cycle.
- Back-to-back: a LOAD in the DONE cycle is accepted. The next START begins one cycle after STOP ends (exactly one idle-high cycle between frames).
- Frame length without HOLD: (WIDTH+2)*DIV cycles, or (WIDTH+3)*DIV with parity. First SOUT=0 appears the cycle after the LOAD edge.
- HOLD:
  - Sampled in START/DATA/PAR/STOP. While HOLD=1, the divider, bit counter and state freeze, and SOUT/SFRAME hold their values. SSTB is suppressed.
  - Resuming continues the same bit with the remaining count, so a held bit lasts DIV + held cycles.
  - HOLD is ignored in IDLE, and does not block LOAD.
- DIV=1: every cycle is a new bit. SSTB is high for every non-held data cycle.
- DIN may change freely after capture; the transmitted word is the captured value.

Optional Feature:
- Macro: FPSER_PARITY_EN.
- Defined:
  - PAR state inserted between DATA and STOP, lasting DIV cycles.
  - SOUT carries even parity over the captured word (XOR of all WIDTH bits), so total ones across data+parity is even.
  - SSTB is not pulsed in PAR. HOLD applies to PAR as to other states.
- Undefined: no PAR state, no parity logic; frame goes DATA -> STOP.

Test Plan:
- Basic frame: WIDTH=32, DIV=4, MSB_FIRST=1, DIN=0x3F800000, single LOAD pulse.
  - SOUT is 0 for 4 cycles, then bits 0,0,1,1,1,1,1,1,1,0...0 at 4 cycles each, then 1 for 4 cycles.
  - SFRAME high 136 cycles, 32 SSTB pulses, DONE 1 cycle, READY low for exactly 136 cycles.
- Parity (FPSER_PARITY_EN defined), same stimulus: 7 ones, so parity bit = 1 for 4 cycles before stop. Frame 140 cycles.
- Back-to-back: LOAD 0xC0000000 asserted in DONE cycle of the previous frame.
  - Exactly one SOUT=1 cycle with SFRAME=0 between frames.
  - Second frame data starts 1,1,0...; ordering with MSB_FIRST=0 reversed (first data bit 0).
- Backpressure: HOLD=1 for 10 cycles starting at divider count 1 of data bit 5.
  - Bit 5 lasts 14 cycles, only one SSTB for bit 5, frame 146 cycles, data unchanged.
- Async reset: CLR pulsed mid-DATA (bit 12), between clock edges.
  - SOUT=1, SFRAME=0, READY=1 immediately, no DONE.
  - Next LOAD 0x00000001 transmits a clean full frame.
- DIV=1, WIDTH=8, DIN=0xA5, LOAD ignored while busy.
  - Frame is 10 cycles: 0,1,0,1,0,0,1,0,1,1.
  - A second LOAD of 0xFF during the frame is not transmitted.
